cl_crc_stream: RTL and testbench

//  Parametrised streaming CRC engine: folds DATA_W-bit beats per cycle into a CRC of any width/polynomial.

---
 rtl/cl_crc_stream.sv | 168 ++++++++++++++++
 tb/tb_cl_crc_stream.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_crc_stream.sv
`default_nettype none
// ============================================================================
//  Module   : cl_crc_stream
//  Brief    : Parametrised streaming CRC engine. Folds DATA_W/8 bytes per
//             accepted beat into a CRC of any width/polynomial and emits one
//             registered result per frame on a valid/ready output.
//  Options  : `define CL_CRC_CHECK_EN adds the m_ok port, which flags a final
//             CRC equal to RESIDUE (frame carries its own transmitted CRC).
//  Revision : 1.0  initial release
// ============================================================================
module cl_crc_stream #(
    parameter int          CRC_W  = 32,
    parameter logic [63:0] POLY   = 64'h0000_0000_04C1_1DB7,
    parameter logic [63:0] INIT   = 64'h0000_0000_FFFF_FFFF,
    parameter logic [63:0] XOROUT = 64'h0000_0000_FFFF_FFFF,
    parameter bit          REFIN  = 1'b1,
    parameter bit          REFOUT = 1'b1,
    parameter int          DATA_W = 32
`ifdef CL_CRC_CHECK_EN
    ,
    parameter logic [63:0] RESIDUE = 64'h0000_0000_2144_DF1C
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    input  logic [DATA_W/8-1:0]   s_keep,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CRC_W-1:0]      m_crc
`ifdef CL_CRC_CHECK_EN
    ,
    output logic                  m_ok
`endif
);

    localparam int               c_lanes  = DATA_W / 8;
    localparam logic [CRC_W-1:0] c_poly   = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] c_init   = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] c_xorout = XOROUT[CRC_W-1:0];

    // Frame position: IDLE means the running register still holds INIT.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACC  = 1'b1;

    // Elaboration-time sanity checks on the configuration.
    if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_data_w
        $error("cl_crc_stream: DATA_W (%0d) must be a non-zero multiple of 8", DATA_W);
    end
    if (CRC_W < 8 || CRC_W > 64) begin : g_bad_crc_w
        $error("cl_crc_stream: CRC_W (%0d) must lie in 8..64", CRC_W);
    end

    // One byte through a bit-serial LFSR in normal (MSB-first) register form.
    // Reflected input is handled by feeding the byte LSB first.
    function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c,
                                                  input logic [7:0]       d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int b = 0; b < 8; b++) begin
            fb = r[CRC_W-1] ^ (REFIN ? d[b] : d[7-b]);
            r  = {r[CRC_W-2:0], 1'b0};
            if (fb) begin
                r = r ^ c_poly;
            end
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] bit_rev(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        r = '0;
        for (int b = 0; b < CRC_W; b++) begin
            r[b] = v[CRC_W-1-b];
        end
        return r;
    endfunction

    logic [0:0]       r_state;
    logic [CRC_W-1:0] r_crc;
    logic             r_m_valid;
    logic [CRC_W-1:0] r_m_crc;

    logic             w_accept;
    logic             w_last_acc;
    logic [CRC_W-1:0] w_crc_base;
    logic [CRC_W-1:0] w_fold;
    logic [CRC_W-1:0] w_final;

    // The input stalls only while a result is held against backpressure.
    assign s_ready    = !r_m_valid || m_ready;
    assign w_accept   = s_valid && s_ready;
    assign w_last_acc = w_accept && s_last;
    assign w_crc_base = (r_state == ST_IDLE) ? c_init : r_crc;

    // Fold all enabled lanes of the current beat, lane 0 first in time.
    // Keep only masks lanes on the last beat of a frame.
    always_comb begin
        w_fold = w_crc_base;
        for (int i = 0; i < c_lanes; i++) begin
            if (!s_last || s_keep[i]) begin
                w_fold = crc_byte(w_fold, s_data[8*i +: 8]);
            end
        end
    end

    // Output conditioning applied to the fully folded register.
    always_comb begin
        w_final = (REFOUT ? bit_rev(w_fold) : w_fold) ^ c_xorout;
    end

    // Frame state and running register; the last beat reloads INIT so the
    // next frame can start on the very next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_crc   <= c_init;
        end else if (w_accept) begin
            if (s_last) begin
                r_state <= ST_IDLE;
                r_crc   <= c_init;
            end else begin
                r_state <= ST_ACC;
                r_crc   <= w_fold;
            end
        end
    end

    // Result register: loads on an accepted last beat, clears on handshake,
    // holds otherwise. A load in the handshake cycle keeps m_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_crc   <= '0;
        end else if (w_last_acc) begin
            r_m_valid <= 1'b1;
            r_m_crc   <= w_final;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid = r_m_valid;
    assign m_crc   = r_m_crc;

`ifdef CL_CRC_CHECK_EN
    localparam logic [CRC_W-1:0] c_residue = RESIDUE[CRC_W-1:0];

    logic r_m_ok;

    // Residue flag travels with the CRC it was computed from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_ok <= 1'b0;
        end else if (w_last_acc) begin
            r_m_ok <= (w_final == c_residue);
        end
    end

    assign m_ok = r_m_ok;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cl_crc_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cl_crc_stream
//  Brief    : Directed self-checking bench for cl_crc_stream (CRC-32 default
//             instance plus a CRC-16/CCITT byte-wide instance).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cl_crc_stream;

    logic        clk;
    logic        rst_n;

    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_crc;

    logic        s16_valid;
    logic        s16_ready;
    logic [7:0]  s16_data;
    logic [0:0]  s16_keep;
    logic        s16_last;
    logic        m16_valid;
    logic        m16_ready;
    logic [15:0] m16_crc;

`ifdef CL_CRC_CHECK_EN
    logic        m_ok;
    logic        m16_ok;
`endif

    int n_cmp;
    int n_err;
    int stall_cnt;

    cl_crc_stream dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_keep  (s_keep),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_crc   (m_crc)
`ifdef CL_CRC_CHECK_EN
        ,
        .m_ok    (m_ok)
`endif
    );

    cl_crc_stream #(
        .CRC_W  (16),
        .POLY   (64'h1021),
        .INIT   (64'hFFFF),
        .XOROUT (64'h0),
        .REFIN  (1'b0),
        .REFOUT (1'b0),
        .DATA_W (8)
    ) dut16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s16_valid),
        .s_ready (s16_ready),
        .s_data  (s16_data),
        .s_keep  (s16_keep),
        .s_last  (s16_last),
        .m_valid (m16_valid),
        .m_ready (m16_ready),
        .m_crc   (m16_crc)
`ifdef CL_CRC_CHECK_EN
        ,
        .m_ok    (m16_ok)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a beat at posedge+1 and return at posedge+1 after it is taken.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int w;
        w       = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        #1;
        while (!s_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!s_ready) begin
            check_eq("s_ready_timeout", 64'(s_ready), 64'd1);
        end
        stall_cnt += w;
        @(posedge clk);
        #1;
    endtask

    task automatic send16(input logic [7:0] d, input logic l);
        int w;
        w         = 0;
        s16_valid = 1'b1;
        s16_data  = d;
        s16_keep  = 1'b1;
        s16_last  = l;
        #1;
        while (!s16_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!s16_ready) begin
            check_eq("s16_ready_timeout", 64'(s16_ready), 64'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic frame_check_value();
        send_beat(32'h34333231, 4'hF, 1'b0);
        send_beat(32'h38373635, 4'hF, 1'b0);
        send_beat(32'h00000039, 4'h1, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_err = 0; stall_cnt = 0;
        rst_n = 1'b0;
        s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; m_ready = 1'b1;
        s16_valid = 1'b0; s16_data = '0; s16_keep = '0; s16_last = 1'b0; m16_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_m_valid", 64'(m_valid), 64'd0);
        check_eq("rst_m_crc",   64'(m_crc),   64'd0);
        check_eq("rst_s_ready", 64'(s_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: "123456789" over three beats, partial last beat.
        frame_check_value();
        s_valid = 1'b0;
        check_eq("t1_valid", 64'(m_valid), 64'd1);
        check_eq("t1_crc",   64'(m_crc),   64'hCBF43926);
        @(posedge clk);
        #1;
        check_eq("t1_consumed", 64'(m_valid), 64'd0);

        // Zero-length frame: single last beat with no lanes kept.
        send_beat(32'hDEADBEEF, 4'h0, 1'b1);
        s_valid = 1'b0;
        check_eq("zlen_valid", 64'(m_valid), 64'd1);
        check_eq("zlen_crc",   64'(m_crc),   64'h0);
        @(posedge clk);
        #1;

        // Test 2: CRC-16/CCITT-FALSE, one byte per beat.
        for (int i = 0; i < 9; i++) begin
            send16(8'(8'h31 + i), i == 8);
        end
        s16_valid = 1'b0;
        check_eq("t2_valid", 64'(m16_valid), 64'd1);
        check_eq("t2_crc",   64'(m16_crc),   64'h29B1);
        @(posedge clk);
        #1;

        // Test 3: two frames back to back with s_valid held high.
        stall_cnt = 0;
        frame_check_value();
        check_eq("t3_f1_valid", 64'(m_valid), 64'd1);
        check_eq("t3_f1_crc",   64'(m_crc),   64'hCBF43926);
        send_beat(32'h34333231, 4'hF, 1'b0);
        check_eq("t3_mid_valid", 64'(m_valid), 64'd0);
        send_beat(32'h38373635, 4'hF, 1'b0);
        send_beat(32'h00000039, 4'h1, 1'b1);
        s_valid = 1'b0;
        check_eq("t3_f2_valid", 64'(m_valid), 64'd1);
        check_eq("t3_f2_crc",   64'(m_crc),   64'hCBF43926);
        check_eq("t3_stall",    64'(stall_cnt), 64'd0);
        @(posedge clk);
        #1;

        // Test 4: hold the result under backpressure, garbage on the input.
        m_ready = 1'b0;
        frame_check_value();
        s_valid = 1'b1;
        s_data  = 'x;
        s_keep  = 'x;
        s_last  = 1'b0;
        check_eq("t4_valid0", 64'(m_valid), 64'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("t4_hold_valid", 64'(m_valid), 64'd1);
        check_eq("t4_hold_crc",   64'(m_crc),   64'hCBF43926);
        check_eq("t4_stall",      64'(s_ready), 64'd0);
        s_data  = 32'h34333231;
        s_keep  = 4'h0;
        m_ready = 1'b1;
        #1;
        check_eq("t4_release", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        check_eq("t4_consumed", 64'(m_valid), 64'd0);
        send_beat(32'h38373635, 4'h0, 1'b0);
        send_beat(32'hDEADBE39, 4'h1, 1'b1);
        s_valid = 1'b0;
        check_eq("t4_f2_valid", 64'(m_valid), 64'd1);
        check_eq("t4_f2_crc",   64'(m_crc),   64'hCBF43926);
        @(posedge clk);
        #1;

        // Test 5: reset in the middle of a frame, then a clean frame.
        send_beat(32'h34333231, 4'hF, 1'b0);
        send_beat(32'h38373635, 4'hF, 1'b0);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_eq("t5_rst_valid", 64'(m_valid), 64'd0);
        check_eq("t5_rst_crc",   64'(m_crc),   64'd0);
        check_eq("t5_rst_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        frame_check_value();
        s_valid = 1'b0;
        check_eq("t5_valid", 64'(m_valid), 64'd1);
        check_eq("t5_crc",   64'(m_crc),   64'hCBF43926);
        @(posedge clk);
        #1;

        // Test 6: frame carrying its own CRC yields the residue.
        send_beat(32'h34333231, 4'hF, 1'b0);
        send_beat(32'h38373635, 4'hF, 1'b0);
        send_beat(32'hF4392639, 4'hF, 1'b0);
        send_beat(32'h000000CB, 4'h1, 1'b1);
        s_valid = 1'b0;
        check_eq("t6_crc", 64'(m_crc), 64'h2144DF1C);
`ifdef CL_CRC_CHECK_EN
        check_eq("t6_ok", 64'(m_ok), 64'd1);
`endif
        @(posedge clk);
        #1;
        send_beat(32'h34333230, 4'hF, 1'b0);
        send_beat(32'h38373635, 4'hF, 1'b0);
        send_beat(32'hF4392639, 4'hF, 1'b0);
        send_beat(32'h000000CB, 4'h1, 1'b1);
        s_valid = 1'b0;
        check_eq("t6_flip_valid", 64'(m_valid), 64'd1);
        check_eq("t6_flip_is_res", 64'(m_crc == 32'h2144DF1C), 64'd0);
`ifdef CL_CRC_CHECK_EN
        check_eq("t6_flip_ok", 64'(m_ok), 64'd0);
`endif
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
